// File: rtl/bus_router_if.sv
// CPU-side request/response and shared target-bus signals of the system bus router.
interface bus_router_if;
  // CPU load/store port
  logic        i_req;
  logic        i_we;
  logic [31:0] i_address;
  logic [31:0] i_wdata;
  logic [3:0]  i_byte_en;
  logic        o_ack;
  logic        o_err;
  logic [31:0] o_rdata;
  // Shared target bus
  logic [7:0]   o_slv_req;
  logic         o_slv_we;
  logic [31:0]  o_slv_address;
  logic [31:0]  o_slv_wdata;
  logic [3:0]   o_slv_byte_en;
  logic [7:0]   i_slv_ack;
  logic [255:0] i_slv_rdata;

  // Router view
  modport slave (
    input  i_req, i_we, i_address, i_wdata, i_byte_en, i_slv_ack, i_slv_rdata,
    output o_ack, o_err, o_rdata, o_slv_req, o_slv_we, o_slv_address, o_slv_wdata,
           o_slv_byte_en
  );

  // CPU plus targets view
  modport master (
    output i_req, i_we, i_address, i_wdata, i_byte_en, i_slv_ack, i_slv_rdata,
    input  o_ack, o_err, o_rdata, o_slv_req, o_slv_we, o_slv_address, o_slv_wdata,
           o_slv_byte_en
  );
endinterface

// File: rtl/bus_router.sv
// Single-master bus router: latches one CPU request, decodes it to a one-hot target select,
// holds it on the shared target bus until the target acks or the timeout expires, and
// returns a one-cycle completion pulse (with error flag) to the CPU.
module bus_router #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] BOOT_LIMIT     = 32'h00002000
) (
  input logic         i_clk,
  input logic         i_rst_n,
  bus_router_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;
  localparam logic [1:0] StErr  = 2'd3;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  slv_req_q, slv_req_d;
  logic        slv_we_q, slv_we_d;
  logic [31:0] slv_addr_q, slv_addr_d;
  logic [31:0] slv_wdata_q, slv_wdata_d;
  logic [3:0]  slv_be_q, slv_be_d;

  logic [7:0]  dec_sel;
  logic        sel_ack;
  logic [31:0] sel_rdata;

  // Address decode of the live CPU address; only consumed in IDLE. Boot region has priority.
  always_comb begin
    dec_sel = 8'h00;
    if (bus.i_address < BOOT_LIMIT) begin
      dec_sel = 8'h01;
    end else begin
      case (bus.i_address[31:28])
        4'h1:    dec_sel = 8'h02;
        4'h2:    dec_sel = 8'h04;
        4'h3:    dec_sel = 8'h08;
        4'h4:    dec_sel = 8'h10;
        4'h5:    dec_sel = 8'h20;
        4'h6:    dec_sel = 8'h40;
        4'h7:    dec_sel = 8'h80;
        default: dec_sel = 8'h00;
      endcase
    end
  end

  // Ack and read data of the currently selected target only; other targets are masked off.
  always_comb begin
    sel_ack   = |(bus.i_slv_ack & slv_req_q);
    sel_rdata = 32'h0;
    for (int k = 0; k < 8; k++) begin
      if (slv_req_q[k]) begin
        sel_rdata = sel_rdata | bus.i_slv_rdata[32*k +: 32];
      end
    end
  end

  // Next-state logic; completion outputs are registered on the transition into RESP/ERR.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = 32'h0;
    slv_req_d   = slv_req_q;
    slv_we_d    = slv_we_q;
    slv_addr_d  = slv_addr_q;
    slv_wdata_d = slv_wdata_q;
    slv_be_d    = slv_be_q;
    case (state_q)
      StIdle: begin
        if (bus.i_req) begin
          slv_we_d    = bus.i_we;
          slv_addr_d  = bus.i_address;
          slv_wdata_d = bus.i_wdata;
          slv_be_d    = bus.i_byte_en;
          cnt_d       = 16'h0;
          if (dec_sel != 8'h00) begin
            state_d   = StReq;
            slv_req_d = dec_sel;
          end else begin
            state_d = StErr;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      StReq: begin
        // Ack is checked first so an ack on the expiry cycle still completes normally.
        if (sel_ack) begin
          state_d   = StResp;
          slv_req_d = 8'h00;
          ack_d     = 1'b1;
          rdata_d   = slv_we_q ? 32'h0 : sel_rdata;
        end else if (cnt_q == TimeoutLast) begin
          state_d   = StErr;
          slv_req_d = 8'h00;
          ack_d     = 1'b1;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 16'h0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      slv_req_q   <= 8'h00;
      slv_we_q    <= 1'b0;
      slv_addr_q  <= 32'h0;
      slv_wdata_q <= 32'h0;
      slv_be_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      slv_req_q   <= slv_req_d;
      slv_we_q    <= slv_we_d;
      slv_addr_q  <= slv_addr_d;
      slv_wdata_q <= slv_wdata_d;
      slv_be_q    <= slv_be_d;
    end
  end

  assign bus.o_ack         = ack_q;
  assign bus.o_err         = err_q;
  assign bus.o_rdata       = rdata_q;
  assign bus.o_slv_req     = slv_req_q;
  assign bus.o_slv_we      = slv_we_q;
  assign bus.o_slv_address = slv_addr_q;
  assign bus.o_slv_wdata   = slv_wdata_q;
  assign bus.o_slv_byte_en = slv_be_q;

endmodule

// File: doc/bus_router.md
# bus_router

Single-master system bus router between the CPU load/store port and the eight memory-mapped targets (bootloader ROM, SDRAM, GPU, PS/2, GPIO, HEX, test, SD card). It latches one CPU request and decodes its address into a one-hot target select. It then holds the request on the shared target bus until the selected target acknowledges, and returns read data plus a one-cycle completion pulse to the CPU. Unmapped addresses and unresponsive targets complete with an error instead of hanging the core.

## Interface
- `TIMEOUT_CYCLES`, 1024: max cycles in REQ without target ack before error completion; legal range 2..65535.
- `BOOT_LIMIT`, 32'h00002000: exclusive upper bound of the bootloader region (8 kB); simulation builds set 32'h00010000.
- `i_clk` input 1: system clock, all logic rising-edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_req` input 1: CPU request; held high by CPU until `o_ack`.
- `i_we` input 1: 1 = write, 0 = read.
- `i_address` input 32: byte address.
- `i_wdata` input 32: write data.
- `i_byte_en` input 4: byte lanes for writes.
- `o_ack` output 1: one-cycle completion pulse.
- `o_err` output 1: qualifies `o_ack`; 1 = unmapped address or timeout.
- `o_rdata` output 32: read data, valid only while `o_ack`=1 and `o_err`=0.
- `o_slv_req` output 8: one-hot target request; bit order boot, sdram, gpu, ps2, gpio, hex, test, sd_card (bit 0..7).
- `o_slv_we`, `o_slv_address`, `o_slv_wdata`, `o_slv_byte_en` outputs 1/32/32/4: registered copies of the latched request, shared by all targets.
- `i_slv_ack` input 8: per-target ack, one bit per target in the same order.
- `i_slv_rdata` input 256: per-target read data, target k on bits [32k+31:32k].

## Operation
- Decode, exclusive upper bounds:
  - boot: below `BOOT_LIMIT`.
  - sdram: 0x1000_0000–0x2000_0000.
  - gpu: 0x2000_0000–0x3000_0000.
  - ps2: 0x3000_0000–0x4000_0000.
  - gpio: 0x4000_0000–0x5000_0000.
  - hex: 0x5000_0000–0x6000_0000.
  - test: 0x6000_0000–0x7000_0000.
  - sd_card: 0x7000_0000–0x8000_0000.
  - All other addresses are unmapped.
- FSM states IDLE, REQ, RESP, ERR.
- IDLE: when `i_req`=1, latch we/address/wdata/byte_en and decode.
  - Mapped address: go to REQ with `o_slv_req` = one-hot select.
  - Unmapped address: go to ERR; no target sees a request.
- REQ: hold `o_slv_req` and the bus outputs stable; the timeout counter increments each cycle.
  - Selected target's ack = 1: capture that target's rdata (zero for writes), drop `o_slv_req`, go to RESP.
  - Counter reaches `TIMEOUT_CYCLES`-1 with no ack: drop `o_slv_req`, go to ERR.
  - Acks from non-selected targets are ignored.
- RESP: `o_ack`=1, `o_err`=0, `o_rdata` = captured data; next state IDLE.
- ERR: `o_ack`=1, `o_err`=1, `o_rdata`=0; next state IDLE.
- `i_req` is ignored outside IDLE. The CPU drops `i_req` the cycle after `o_ack`, so the router always spends one IDLE cycle between transactions.
- Timeout counter: 16 bits, cleared on every entry to REQ.

## Timing
- Reset (async assert, sync-to-clock deassert handled upstream):
  - State = IDLE.
  - `o_ack`, `o_err`, `o_slv_req`, `o_slv_we` = 0.
  - `o_rdata`, `o_slv_address`, `o_slv_wdata` = 0; `o_slv_byte_en` = 0.
  - Timeout counter = 0.
- Reset asserted mid-transaction aborts it immediately. No `o_ack` follows and `o_slv_req` drops asynchronously.
- Mapped access, `i_req` sampled at edge t:
  - `o_slv_req` high from t+1.
  - If the target acks combinationally in its first request cycle, `o_ack` is high for the cycle after edge t+2.
  - Each extra target wait cycle adds one cycle.
- Unmapped access: `o_ack` and `o_err` high from edge t+1 for one cycle.
- Timeout: `o_slv_req` is high for exactly `TIMEOUT_CYCLES` cycles, then ERR completes on the following cycle.
- Ack arriving on the same edge the counter expires: the ack wins, giving normal RESP.
- All outputs are registered; no combinational path from CPU inputs to target outputs.

## Test plan
- Read 0x1000_0004; sdram acks 3 cycles after `o_slv_req` with 0xDEADBEEF → `o_slv_req`=8'h02 for 3 cycles, then `o_ack`=1, `o_err`=0, `o_rdata`=0xDEADBEEF.
- Write 0x4000_0000, wdata 0x0000_00A5, byte_en 4'b0001; gpio acks in its first request cycle → `o_slv_req`=8'h10, `o_slv_we`=1, bus fields match; `o_ack` at t+2, `o_rdata`=0.
- Read 0x0000_3000 with `BOOT_LIMIT`=0x2000 → no `o_slv_req` bit ever set; `o_ack`=`o_err`=1 at t+1. Repeat with 0x8000_0000 and 0xFFFF_FFFC: same result.
- `TIMEOUT_CYCLES`=8; read 0x2000_0000, gpu never acks; hex acks spuriously → `o_slv_req`=8'h04 for exactly 8 cycles, then `o_ack`=`o_err`=1; spurious hex ack has no effect.
- Boundary decode: 0x0000_1FFC → 8'h01; 0x1FFF_FFFC → 8'h02; 0x7000_0000 → 8'h80.
- Assert `i_rst_n`=0 during REQ → all outputs 0 immediately. After release, a fresh read to 0x5000_0000 completes normally with `o_slv_req`=8'h20.
